// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer driving the CSR trap-write port and fetch redirect.
// Ports: i_clk/i_rst (sync, active-high); commit-stage i_valid/i_pc/i_inst, exception flags,
// i_target_addr/i_mem_addr (tval sources), i_mret, async level i_irq with i_irq_en,
// i_mtvec/i_mepc from CSR file; o_trap_req/o_trap_pc/o_trap_cause/o_trap_tval to CSR file,
// o_flush (comb), o_stall, o_redirect/o_redirect_pc to fetch.
// Optional: define COTM32_TRAP_VECTORED_EN for vectored interrupt dispatch (mtvec mode 01).
package trap_ctrl_pkg;
  localparam int MXLEN = 32;
  typedef logic [MXLEN-1:0] trap_cause_t;
endpackage

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [MXLEN-1:0] i_pc,
  input  logic [31:0]      i_inst,
  input  logic             i_t_inst_misaligned,
  input  logic [MXLEN-1:0] i_target_addr,
  input  logic             i_t_illegal_inst,
  input  logic             i_t_ebreak,
  input  logic             i_t_ecall,
  input  logic             i_t_load_misaligned,
  input  logic             i_t_store_misaligned,
  input  logic [MXLEN-1:0] i_mem_addr,
  input  logic             i_mret,
  input  logic             i_irq,
  input  logic             i_irq_en,
  input  logic [MXLEN-1:0] i_mtvec,
  input  logic [MXLEN-1:0] i_mepc,
  output logic             o_trap_req,
  output logic [MXLEN-1:0] o_trap_pc,
  output trap_cause_t      o_trap_cause,
  output logic [MXLEN-1:0] o_trap_tval,
  output logic             o_flush,
  output logic             o_stall,
  output logic             o_redirect,
  output logic [MXLEN-1:0] o_redirect_pc
);
  typedef enum logic [1:0] {IDLE, TRAP, REDIR, RET} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic take_irq, trap, accept;
  trap_cause_t cause_n;
  logic [MXLEN-1:0] tval_n, base, target;

  always_ff @(posedge i_clk)
    sync <= i_rst ? '0 : {sync[SYNC_STAGES-2:0], i_irq};

  assign take_irq = sync[SYNC_STAGES-1] & i_irq_en;
  assign trap = take_irq | i_t_inst_misaligned | i_t_illegal_inst | i_t_ebreak | i_t_ecall |
                i_t_load_misaligned | i_t_store_misaligned;
  assign accept = (state == IDLE) & i_valid & ~i_rst;
  assign o_flush = accept & (trap | i_mret);

  always_comb begin
    cause_n = take_irq            ? {1'b1, (MXLEN-1)'(11)} :
              i_t_inst_misaligned ? MXLEN'(0) :
              i_t_illegal_inst    ? MXLEN'(2) :
              i_t_ebreak          ? MXLEN'(3) :
              i_t_ecall           ? MXLEN'(11) :
              i_t_load_misaligned ? MXLEN'(4) : MXLEN'(6);
    tval_n  = take_irq            ? '0 :
              i_t_inst_misaligned ? i_target_addr :
              i_t_illegal_inst    ? MXLEN'(i_inst) :
              i_t_ebreak          ? i_pc :
              i_t_ecall           ? '0 : i_mem_addr;
  end

  assign base = {i_mtvec[MXLEN-1:2], 2'b00};
`ifdef COTM32_TRAP_VECTORED_EN
  // Only interrupts vector; exceptions always land on base.
  assign target = (i_mtvec[1:0] == 2'b01 && o_trap_cause[MXLEN-1]) ?
                  base + {o_trap_cause[MXLEN-3:0], 2'b00} : base;
`else
  logic unused_mode;
  assign unused_mode = &{1'b0, i_mtvec[1:0]};
  assign target = base;
`endif
  // CSR values are read live so the redirect sees the completed trap write.
  assign o_redirect_pc = state == REDIR ? target : state == RET ? i_mepc : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_trap_req   <= 1'b0;
      o_redirect   <= 1'b0;
      o_stall      <= 1'b0;
      o_trap_pc    <= '0;
      o_trap_cause <= '0;
      o_trap_tval  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && trap) begin
            state        <= TRAP;
            o_trap_req   <= 1'b1;
            o_stall      <= 1'b1;
            o_trap_pc    <= i_pc;
            o_trap_cause <= cause_n;
            o_trap_tval  <= tval_n;
          end else if (accept && i_mret) begin
            state      <= RET;
            o_redirect <= 1'b1;
            o_stall    <= 1'b1;
          end
        end
        TRAP: begin
          state      <= REDIR;
          o_trap_req <= 1'b0;
          o_redirect <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          o_redirect <= 1'b0;
          o_stall    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;
  logic clk = 0, rst = 1, valid = 0, inst_mis = 0, illegal = 0, ebreak = 0, ecall = 0;
  logic load_mis = 0, store_mis = 0, mret = 0, irq = 0, irq_en = 0;
  logic [31:0] pc = 0, inst = 0, target_addr = 0, mem_addr = 0, mtvec = 0, mepc = 0;
  logic trap_req, flush, stall, redirect;
  logic [31:0] trap_pc, trap_tval, redirect_pc;
  trap_cause_t trap_cause;
  int n_cmp = 0, n_err = 0;

  trap_ctrl #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_inst(inst),
    .i_t_inst_misaligned(inst_mis), .i_target_addr(target_addr),
    .i_t_illegal_inst(illegal), .i_t_ebreak(ebreak), .i_t_ecall(ecall),
    .i_t_load_misaligned(load_mis), .i_t_store_misaligned(store_mis),
    .i_mem_addr(mem_addr), .i_mret(mret), .i_irq(irq), .i_irq_en(irq_en),
    .i_mtvec(mtvec), .i_mepc(mepc), .o_trap_req(trap_req), .o_trap_pc(trap_pc),
    .o_trap_cause(trap_cause), .o_trap_tval(trap_tval), .o_flush(flush),
    .o_stall(stall), .o_redirect(redirect), .o_redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    {valid, inst_mis, illegal, ebreak, ecall, load_mis, store_mis, mret} = '0;
  endtask

  // Inputs already applied at a negedge: checks flush@T, trap_req@T+1, redirect@T+2, idle@T+3.
  task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] ecause,
                          input logic [31:0] etval, input logic [31:0] eredir);
    #1;
    chk({tag, "_flush"}, flush, 1);
    chk({tag, "_stall_T"}, stall, 0);
    @(negedge clk);
    clear_in();
    #1;
    chk({tag, "_req"}, trap_req, 1);
    chk({tag, "_pc"}, trap_pc, epc);
    chk({tag, "_cause"}, trap_cause, ecause);
    chk({tag, "_tval"}, trap_tval, etval);
    chk({tag, "_stall_T1"}, stall, 1);
    chk({tag, "_redir_T1"}, redirect, 0);
    @(negedge clk);
    chk({tag, "_redir"}, redirect, 1);
    chk({tag, "_redir_pc"}, redirect_pc, eredir);
    chk({tag, "_req_T2"}, trap_req, 0);
    @(negedge clk);
    chk({tag, "_idle_stall"}, stall, 0);
    chk({tag, "_idle_redir"}, redirect, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", trap_req, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_rpc", redirect_pc, 0);
    rst = 0;
    mtvec = 32'h200;
    @(negedge clk);
    valid = 1; pc = 32'h100; inst = 32'hFFFF_FFFF; illegal = 1;
    trap_seq("illegal", 32'h100, 2, 32'hFFFF_FFFF, 32'h200);
    valid = 1; pc = 32'h140; mem_addr = 32'h1003; load_mis = 1;
    trap_seq("load_mis", 32'h140, 4, 32'h1003, 32'h200);
    valid = 1; pc = 32'h120; inst = 32'h0000_0073; illegal = 1; ecall = 1;
    trap_seq("ill_ecall", 32'h120, 2, 32'h0000_0073, 32'h200);
    valid = 1; pc = 32'h130; target_addr = 32'h2002; inst_mis = 1; ebreak = 1;
    trap_seq("inst_mis", 32'h130, 0, 32'h2002, 32'h200);
    valid = 1; pc = 32'h134; ebreak = 1; store_mis = 1; mem_addr = 32'h55;
    trap_seq("ebreak", 32'h134, 3, 32'h134, 32'h200);
    valid = 1; pc = 32'h138; ecall = 1; mret = 1;
    trap_seq("ecall", 32'h138, 11, 0, 32'h200);
    valid = 1; pc = 32'h13C; store_mis = 1; mem_addr = 32'h2001;
    trap_seq("store_mis", 32'h13C, 6, 32'h2001, 32'h200);
    // Valid low: flags must be ignored.
    illegal = 1;
    #1 chk("novalid_flush", flush, 0);
    @(negedge clk);
    chk("novalid_stall", stall, 0);
    clear_in();
    // MRET.
    mepc = 32'h104; valid = 1; mret = 1;
    #1 chk("mret_flush", flush, 1);
    @(negedge clk);
    clear_in();
    chk("mret_redir", redirect, 1);
    chk("mret_rpc", redirect_pc, 32'h104);
    chk("mret_req", trap_req, 0);
    chk("mret_stall", stall, 1);
    @(negedge clk);
    chk("mret_idle_stall", stall, 0);
    chk("mret_idle_redir", redirect, 0);
    chk("mret_idle_req", trap_req, 0);
    // Interrupt disabled: no trap even after sync.
    irq = 1; irq_en = 0; valid = 1; pc = 32'h170;
    repeat (3) @(negedge clk);
    chk("irq_dis_flush", flush, 0);
    irq = 0; clear_in();
    repeat (3) @(negedge clk);
    // Interrupt: rises at cycle 0, visible two cycles later.
    mtvec = 32'h201; irq = 1; irq_en = 1; valid = 1; pc = 32'h180;
    #1 chk("irq_c0_flush", flush, 0);
    @(negedge clk);
    chk("irq_c1_flush", flush, 0);
    @(negedge clk);
    irq = 0;
`ifdef COTM32_TRAP_VECTORED_EN
    trap_seq("irq", 32'h180, 32'h8000_000B, 0, 32'h22C);
`else
    trap_seq("irq", 32'h180, 32'h8000_000B, 0, 32'h200);
`endif
    chk("irq_cleared_flush", flush, 0);
    // Reset while in TRAP.
    valid = 1; pc = 32'h1A0; illegal = 1;
    @(negedge clk);
    clear_in();
    chk("rst_mid_req", trap_req, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_req0", trap_req, 0);
    chk("rst_mid_redir", redirect, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_rpc", redirect_pc, 0);
    chk("rst_mid_pc", trap_pc, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_after_redir", redirect, 0);
    chk("rst_after_stall", stall, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
